posicionador_ejes: RTL and testbench

POSICIONADOR_EJES -- requirements
Module: posicionador_ejes

---
 rtl/posicionador_ejes.sv | 231 +++++++++++++++++++++++
 tb/tb_posicionador_ejes.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posicionador_ejes.sv
// ---------------------------------------------------------------------------
// posicionador_ejes
//
// Two-axis tool positioner for a cutting table. A controller presents target
// coordinates one at a time. For each one the block walks the tool toward it,
// one unit per axis on every step tick, then pulses dato_siguiente to request
// the next coordinate. A latched target of (0,0) ends the program.
//
// Optional feature (compile-time macro RETORNO_ORIGEN_EN):
//   defined     - at the end of the program the tool is stepped back to (0,0)
//                 with the tool off, and corte_terminado rises only at (0,0).
//   not defined - corte_terminado rises in the first FIN cycle and the
//                 position is held.
//
// Parameters
//   bits_eje      width of each axis coordinate
//   periodo_paso  clock cycles between step ticks (>= 2)
//   ancho_pulso   dato_siguiente high time, and settle time after it
//
// Ports
//   clock            in   system clock, rising edge
//   reset            in   asynchronous, active-high
//   cortando         in   run the cut program (level)
//   x_objetivo       in   target X coordinate
//   y_objetivo       in   target Y coordinate
//   paso_x, paso_y   out  one-cycle step pulse per axis
//   dir_x, dir_y     out  1 = increment, 0 = decrement
//   x_posicion       out  current X position
//   y_posicion       out  current Y position
//   herramienta      out  tool enable
//   dato_siguiente   out  request for the next coordinate
//   corte_terminado  out  program finished
// ---------------------------------------------------------------------------
module posicionador_ejes #(
  parameter int bits_eje     = 6,
  parameter int periodo_paso = 8,
  parameter int ancho_pulso  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cortando,
  input  logic [bits_eje-1:0] x_objetivo,
  input  logic [bits_eje-1:0] y_objetivo,
  output logic                paso_x,
  output logic                paso_y,
  output logic                dir_x,
  output logic                dir_y,
  output logic [bits_eje-1:0] x_posicion,
  output logic [bits_eje-1:0] y_posicion,
  output logic                herramienta,
  output logic                dato_siguiente,
  output logic                corte_terminado
);

  // FSM encoding
  localparam logic [2:0] REPOSO  = 3'd0;
  localparam logic [2:0] CARGAR  = 3'd1;
  localparam logic [2:0] MOVER   = 3'd2;
  localparam logic [2:0] LLEGADA = 3'd3;
  localparam logic [2:0] ASENTAR = 3'd4;
  localparam logic [2:0] FIN     = 3'd5;

  localparam int DIV_W = (periodo_paso > 2) ? $clog2(periodo_paso) : 1;
  localparam int PUL_W = (ancho_pulso  > 2) ? $clog2(ancho_pulso)  : 1;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(periodo_paso - 1);
  localparam logic [PUL_W-1:0]    PUL_LAST = PUL_W'(ancho_pulso - 1);
  localparam logic [bits_eje-1:0] UNO      = bits_eje'(1);

  // State registers
  logic [2:0]          state_q,   state_d;
  logic [bits_eje-1:0] x_obj_q,   x_obj_d;
  logic [bits_eje-1:0] y_obj_q,   y_obj_d;
  logic [bits_eje-1:0] x_pos_q,   x_pos_d;
  logic [bits_eje-1:0] y_pos_q,   y_pos_d;
  logic                dir_x_q,   dir_x_d;
  logic                dir_y_q,   dir_y_d;
  logic                paso_x_q,  paso_x_d;
  logic                paso_y_q,  paso_y_d;
  logic [DIV_W-1:0]    div_q,     div_d;
  logic [PUL_W-1:0]    pul_q,     pul_d;

  // Helpers
  logic tick;        // step divider at its last count
  logic pul_done;    // pulse counter at its last count
  logic falta_x;     // X not yet at its latched target
  logic falta_y;     // Y not yet at its latched target
  logic abortar;     // controller dropped cortando mid-program
  logic avanzar;     // this cycle is a step tick in a stepping state

  assign tick     = (div_q == DIV_LAST);
  assign pul_done = (pul_q == PUL_LAST);
  assign falta_x  = (x_pos_q != x_obj_q);
  assign falta_y  = (y_pos_q != y_obj_q);
  assign abortar  = !cortando && (state_q != REPOSO) && (state_q != FIN);

  always_comb begin
    // NOTE: every next-state value is defaulted before the case so that no
    // path through it leaves a variable unassigned and infers a latch.
    state_d  = state_q;
    x_obj_d  = x_obj_q;
    y_obj_d  = y_obj_q;
    x_pos_d  = x_pos_q;
    y_pos_d  = y_pos_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    paso_x_d = 1'b0;
    paso_y_d = 1'b0;
    avanzar  = 1'b0;

    if (abortar) begin
      // Position and direction are kept; any step due this cycle is dropped.
      state_d = REPOSO;
    end else begin
      case (state_q)
        REPOSO: begin
          if (cortando) state_d = CARGAR;
        end

        CARGAR: begin
          x_obj_d = x_objetivo;
          y_obj_d = y_objetivo;
          if ((x_objetivo == '0) && (y_objetivo == '0)) begin
            state_d = FIN;
`ifdef RETORNO_ORIGEN_EN
            // The walk home always decrements.
            dir_x_d = 1'b0;
            dir_y_d = 1'b0;
`endif
          end else begin
            dir_x_d = (x_objetivo > x_pos_q);
            dir_y_d = (y_objetivo > y_pos_q);
            state_d = MOVER;
          end
        end

        MOVER: begin
          if (!falta_x && !falta_y) state_d = LLEGADA;
          else                      avanzar = tick;
        end

        LLEGADA: begin
          if (pul_done) state_d = ASENTAR;
        end

        ASENTAR: begin
          if (pul_done) state_d = CARGAR;
        end

        FIN: begin
          if (!cortando) state_d = REPOSO;
`ifdef RETORNO_ORIGEN_EN
          // Latched target is (0,0) here, so the MOVER stepping rule
          // walks the tool back to the origin.
          else           avanzar = tick;
`endif
        end

        default: state_d = REPOSO;
      endcase
    end

    // The pulse and the position update are registered together, so the
    // new coordinate is visible in the same cycle as paso_*.
    if (avanzar && falta_x) begin
      paso_x_d = 1'b1;
      x_pos_d  = dir_x_q ? (x_pos_q + UNO) : (x_pos_q - UNO);
    end
    if (avanzar && falta_y) begin
      paso_y_d = 1'b1;
      y_pos_d  = dir_y_q ? (y_pos_q + UNO) : (y_pos_q - UNO);
    end

    // Both counters restart on every state entry.
    if (state_d != state_q)                       div_d = '0;
    else if (tick)                                div_d = '0;
    else                                          div_d = div_q + DIV_W'(1);

    if (state_d != state_q)                       pul_d = '0;
    else if (state_q == LLEGADA || state_q == ASENTAR)
                                                  pul_d = pul_q + PUL_W'(1);
    else                                          pul_d = pul_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= REPOSO;
      x_obj_q  <= '0;
      y_obj_q  <= '0;
      x_pos_q  <= '0;
      y_pos_q  <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      paso_x_q <= 1'b0;
      paso_y_q <= 1'b0;
      div_q    <= '0;
      pul_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state_q  <= state_d;
      x_obj_q  <= x_obj_d;
      y_obj_q  <= y_obj_d;
      x_pos_q  <= x_pos_d;
      y_pos_q  <= y_pos_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      paso_x_q <= paso_x_d;
      paso_y_q <= paso_y_d;
      div_q    <= div_d;
      pul_q    <= pul_d;
    end
  end

  // Outputs decode straight from registers; reset zeroes all of them at once.
  assign paso_x         = paso_x_q;
  assign paso_y         = paso_y_q;
  assign dir_x          = dir_x_q;
  assign dir_y          = dir_y_q;
  assign x_posicion     = x_pos_q;
  assign y_posicion     = y_pos_q;
  assign herramienta    = (state_q == MOVER) || (state_q == LLEGADA) ||
                          (state_q == ASENTAR);
  assign dato_siguiente = (state_q == LLEGADA);
`ifdef RETORNO_ORIGEN_EN
  assign corte_terminado = (state_q == FIN) && (x_pos_q == '0) && (y_pos_q == '0);
`else
  assign corte_terminado = (state_q == FIN);
`endif

endmodule

// File: tb/tb_posicionador_ejes.sv
// ---------------------------------------------------------------------------
// tb_posicionador_ejes
//
// Scoreboard bench for posicionador_ejes (default parameters). The driver
// issues cut programs; a coordinate-level model pushes the expected step,
// coordinate-request and end-of-program events into a queue, and a monitor
// pops and compares them whenever the DUT produces one. Directed programs
// are followed by random ones, a mid-move reset and a mid-move abort.
// Honours RETORNO_ORIGEN_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_posicionador_ejes;

  localparam int W       = 6;
  localparam int PERIODO = 8;
  localparam int ANCHO   = 4;

  localparam int EV_PASO = 0;
  localparam int EV_DATO = 1;
  localparam int EV_FIN  = 2;

  localparam int SIG_DATO  = 0;
  localparam int SIG_CORTE = 1;
  localparam int SIG_PASOX = 2;

  typedef struct {
    int kind;
    int px, py;   // step pulses
    int dx, dy;   // directions
    int x, y;     // position after the event
    int t0;       // step: cycles since previous step/MOVER entry (0 = skip)
                  // dato: cycles from last step/MOVER entry to request
    int t1;       // dato: request width
  } ev_t;

  logic         clock, reset, cortando;
  logic [W-1:0] x_objetivo, y_objetivo;
  logic         paso_x, paso_y, dir_x, dir_y;
  logic [W-1:0] x_posicion, y_posicion;
  logic         herramienta, dato_siguiente, corte_terminado;

  int  errors = 0;
  int  checks = 0;
  ev_t exp_q[$];
  int  mx = 0, my = 0;   // model position

  posicionador_ejes dut (
    .clock           (clock),
    .reset           (reset),
    .cortando        (cortando),
    .x_objetivo      (x_objetivo),
    .y_objetivo      (y_objetivo),
    .paso_x          (paso_x),
    .paso_y          (paso_y),
    .dir_x           (dir_x),
    .dir_y           (dir_y),
    .x_posicion      (x_posicion),
    .y_posicion      (y_posicion),
    .herramienta     (herramienta),
    .dato_siguiente  (dato_siguiente),
    .corte_terminado (corte_terminado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (coordinate level) ----------------
  function automatic ev_t mk(input int kind);
    ev_t e;
    e.kind = kind; e.px = 0; e.py = 0; e.dx = 0; e.dy = 0;
    e.x = mx; e.y = my; e.t0 = 0; e.t1 = 0;
    return e;
  endfunction

  task automatic model_target(input int tx, input int ty);
    ev_t e;
    int  ddx, ddy;
    bit  first;
    if (tx == 0 && ty == 0) begin
`ifdef RETORNO_ORIGEN_EN
      first = 1'b1;
      while (mx != 0 || my != 0) begin
        e = mk(EV_PASO);
        e.px = (mx != 0); e.py = (my != 0);
        if (mx != 0) mx--;
        if (my != 0) my--;
        e.x = mx; e.y = my;
        e.t0 = first ? 0 : PERIODO;
        first = 1'b0;
        exp_q.push_back(e);
      end
`endif
      exp_q.push_back(mk(EV_FIN));
    end else begin
      ddx = (tx > mx); ddy = (ty > my);
      while (mx != tx || my != ty) begin
        e = mk(EV_PASO);
        e.dx = ddx; e.dy = ddy;
        e.px = (mx != tx); e.py = (my != ty);
        if (mx != tx) mx += ddx ? 1 : -1;
        if (my != ty) my += ddy ? 1 : -1;
        e.x = mx; e.y = my; e.t0 = PERIODO;
        exp_q.push_back(e);
      end
      e = mk(EV_DATO);
      e.t0 = 1; e.t1 = ANCHO;
      exp_q.push_back(e);
    end
  endtask

  // ---------------- monitor ----------------
  task automatic take(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event_kind", got.kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", got.kind, e.kind);
      if (got.kind == e.kind) begin
        if (e.kind == EV_PASO) begin
          check("paso_x", got.px, e.px);
          check("paso_y", got.py, e.py);
          if (e.t0 != 0) begin
            check("dir_x_at_step", got.dx, e.dx);
            check("dir_y_at_step", got.dy, e.dy);
            check("step_spacing", got.t0, e.t0);
          end else begin
            check("dir_x_home", got.dx, 0);
            check("dir_y_home", got.dy, 0);
          end
        end else if (e.kind == EV_DATO) begin
          check("dato_latency", got.t0, e.t0);
          check("dato_width", got.t1, e.t1);
        end
        check("pos_x", got.x, e.x);
        check("pos_y", got.y, e.y);
      end
    end
  endtask

  int   cyc = 0, last_cyc = 0, rise_cyc = 0, lat = 0;
  logic herr_p = 1'b0, dato_p = 1'b0, corte_p = 1'b0;

  always @(negedge clock) begin
    ev_t g;
    if (reset) begin
      herr_p = 1'b0; dato_p = 1'b0; corte_p = 1'b0;
    end else begin
      cyc++;
      if (herramienta && !herr_p) last_cyc = cyc;
      g.px = int'(paso_x); g.py = int'(paso_y);
      g.dx = int'(dir_x);  g.dy = int'(dir_y);
      g.x  = int'(x_posicion); g.y = int'(y_posicion);
      g.t1 = 0;
      if (paso_x || paso_y) begin
        g.kind = EV_PASO; g.t0 = cyc - last_cyc; last_cyc = cyc;
        take(g);
      end
      if (dato_siguiente && !dato_p) begin
        rise_cyc = cyc; lat = cyc - last_cyc;
      end
      if (!dato_siguiente && dato_p) begin
        g.kind = EV_DATO; g.t0 = lat; g.t1 = cyc - rise_cyc;
        take(g);
      end
      if (corte_terminado && !corte_p) begin
        g.kind = EV_FIN; g.t0 = 0;
        take(g);
      end
      herr_p = herramienta; dato_p = dato_siguiente; corte_p = corte_terminado;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_sig(input int which, input logic lvl, input int budget,
                          input string name);
    int   ok;
    logic s;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #1;
      case (which)
        SIG_DATO:  s = dato_siguiente;
        SIG_CORTE: s = corte_terminado;
        default:   s = paso_x;
      endcase
      if (s == lvl) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  int prog_x[$], prog_y[$];

  task automatic run_program();
    for (int i = 0; i < prog_x.size(); i++) begin
      if (i > 0) begin
        wait_sig(SIG_DATO, 1'b0, 2000, "dato_low_timeout");
        wait_sig(SIG_DATO, 1'b1, 2000, "dato_rise_timeout");
      end
      x_objetivo = W'(prog_x[i]);
      y_objetivo = W'(prog_y[i]);
      model_target(prog_x[i], prog_y[i]);
      if (i == 0) cortando = 1'b1;
    end
    wait_sig(SIG_CORTE, 1'b1, 2000, "corte_timeout");
    cortando = 1'b0;
    @(negedge clock); #1;
    check("fin_exit_corte", int'(corte_terminado), 0);
    check("fin_exit_herr", int'(herramienta), 0);
    check("fin_hold_x", int'(x_posicion), mx);
    check("fin_hold_y", int'(y_posicion), my);
    repeat (3) @(negedge clock);
    #1;
    check("reposo_stays_corte", int'(corte_terminado), 0);
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_paso_x"}, int'(paso_x), 0);
    check({tag, "_paso_y"}, int'(paso_y), 0);
    check({tag, "_dir_x"}, int'(dir_x), 0);
    check({tag, "_dir_y"}, int'(dir_y), 0);
    check({tag, "_x_pos"}, int'(x_posicion), 0);
    check({tag, "_y_pos"}, int'(y_posicion), 0);
    check({tag, "_herr"}, int'(herramienta), 0);
    check({tag, "_dato"}, int'(dato_siguiente), 0);
    check({tag, "_corte"}, int'(corte_terminado), 0);
  endtask

  initial begin
    int tx, ty;
    reset = 1'b1; cortando = 1'b0; x_objetivo = '0; y_objetivo = '0;
    repeat (2) @(negedge clock);
    #1;
    all_zero("reset");
    reset = 1'b0;

    // Directed program: (3,2), (1,5), (1,5) again, end marker.
    prog_x = '{3, 1, 1, 0};
    prog_y = '{2, 5, 5, 0};
    run_program();

    // Random programs.
    for (int p = 0; p < 3; p++) begin
      prog_x.delete(); prog_y.delete();
      for (int k = 0; k < 4; k++) begin
        do begin
          tx = int'($urandom_range(0, 15));
          ty = int'($urandom_range(0, 15));
        end while (tx == 0 && ty == 0);
        prog_x.push_back(tx); prog_y.push_back(ty);
      end
      prog_x.push_back(0); prog_y.push_back(0);
      run_program();
    end

    // Reset between two ticks of a move.
    reset = 1'b1; @(negedge clock); #1; reset = 1'b0;
    exp_q.delete(); mx = 0; my = 0;
    x_objetivo = W'(3); y_objetivo = W'(2);
    model_target(3, 2);
    cortando = 1'b1;
    wait_sig(SIG_PASOX, 1'b1, 200, "first_step_timeout");
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    all_zero("async_reset");
    exp_q.delete(); mx = 0; my = 0;
    cortando = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    all_zero("after_reset");

    // Abort after the first step toward (3,2).
    x_objetivo = W'(3); y_objetivo = W'(2);
    model_target(3, 2);
    cortando = 1'b1;
    wait_sig(SIG_PASOX, 1'b1, 200, "abort_step_timeout");
    cortando = 1'b0;
    exp_q.delete(); mx = 1; my = 1;
    @(negedge clock); #1;
    check("abort_herr", int'(herramienta), 0);
    check("abort_dato", int'(dato_siguiente), 0);
    check("abort_paso_x", int'(paso_x), 0);
    check("abort_x", int'(x_posicion), 1);
    check("abort_y", int'(y_posicion), 1);
    repeat (30) @(negedge clock);
    #1;
    check("abort_hold_x", int'(x_posicion), 1);
    check("abort_hold_y", int'(y_posicion), 1);

    check("events_left", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
